// File: rtl/udp_cmd_decoder.sv
// UDP payload command decoder: turns command frames into AXI AW/AR
// address handshakes or W bursts, draining and counting malformed frames.
module udp_cmd_decoder #(
   parameter logic [7:0] OP_WR_ADDR = 8'hA0,
   parameter logic [7:0] OP_WR_DATA = 8'hA1,
   parameter logic [7:0] OP_RD_ADDR = 8'hA2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_last,
   output logic        rx_ready,
   output logic [1:0]  awid,
   output logic [1:0]  awburst,
   output logic [7:0]  awlen,
   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [1:0]  arid,
   output logic [1:0]  arburst,
   output logic [7:0]  arlen,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   output logic [7:0]  err_cnt
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_HDR     = 3'd1;
   localparam logic [2:0] S_ADDR    = 3'd2;
   localparam logic [2:0] S_DATA    = 3'd3;
   localparam logic [2:0] S_ISSUE_A = 3'd4;
   localparam logic [2:0] S_BEAT    = 3'd5;
   localparam logic [2:0] S_PAD     = 3'd6;
   localparam logic [2:0] S_DRAIN   = 3'd7;

   logic [2:0]  state;
   logic        op_wr;
   logic        op_dat;
   logic [2:0]  len;
   logic [1:0]  burst;
   logic [1:0]  id;
   logic [31:0] addr;
   logic [1:0]  bcnt;
   logic [2:0]  beat;
   logic        pad_pend;
   logic        drain_pend;
   logic        acc;
   logic        op_known;
   logic        last_beat;
   logic [2:0]  nbeat;
   logic        err_evt;

   assign rx_ready = !rst && (state == S_IDLE || state == S_HDR ||
                              state == S_ADDR || state == S_DATA ||
                              state == S_DRAIN);
   assign acc       = rx_valid && rx_ready;
   assign op_known  = rx_data == OP_WR_ADDR || rx_data == OP_WR_DATA ||
                      rx_data == OP_RD_ADDR;
   assign last_beat = beat == len;
   assign nbeat     = beat + 3'd1;

   assign awid    = id;
   assign arid    = id;
   assign awburst = burst;
   assign arburst = burst;
   assign awlen   = {5'd0, len};
   assign arlen   = {5'd0, len};
   assign awaddr  = addr;
   assign araddr  = addr;

   // One malformed-frame event per frame, flagged on the byte that proves it
   always_comb begin
      err_evt = 1'b0;
      if (acc) begin
         unique case (state)
            S_IDLE:  err_evt = !op_known || rx_last;
            S_HDR:   err_evt = rx_last;
            S_ADDR:  err_evt = (bcnt == 2'd3) ? !rx_last : rx_last;
            S_DATA:  err_evt = rx_last != (bcnt == 2'd3 && last_beat);
            default: err_evt = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         op_wr      <= 1'b0;
         op_dat     <= 1'b0;
         len        <= '0;
         burst      <= '0;
         id         <= '0;
         addr       <= '0;
         bcnt       <= '0;
         beat       <= '0;
         pad_pend   <= 1'b0;
         drain_pend <= 1'b0;
         awvalid    <= 1'b0;
         arvalid    <= 1'b0;
         wvalid     <= 1'b0;
         wdata      <= '0;
         wstrb      <= '0;
         wlast      <= 1'b0;
         err_cnt    <= '0;
      end else begin
         if (err_evt && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
         unique case (state)
            S_IDLE: if (acc) begin
               op_dat <= rx_data == OP_WR_DATA;
               op_wr  <= rx_data == OP_WR_ADDR;
               if (!rx_last)
                  state <= op_known ? S_HDR : S_DRAIN;
            end
            S_HDR: if (acc) begin
               bcnt       <= '0;
               beat       <= '0;
               pad_pend   <= 1'b0;
               drain_pend <= 1'b0;
               if (op_dat) begin
                  len <= rx_data[2:0];
                  if (rx_last) begin
                     wvalid <= 1'b1;
                     wdata  <= '0;
                     wstrb  <= '0;
                     wlast  <= rx_data[2:0] == 3'd0;
                     state  <= S_PAD;
                  end else begin
                     state <= S_DATA;
                  end
               end else begin
                  len   <= rx_data[6:4];
                  burst <= rx_data[3:2];
                  id    <= rx_data[1:0];
                  state <= rx_last ? S_IDLE : S_ADDR;
               end
            end
            S_ADDR: if (acc) begin
               addr <= {addr[23:0], rx_data};
               bcnt <= bcnt + 2'd1;
               if (bcnt == 2'd3) begin
                  if (rx_last) begin
                     awvalid <= op_wr;
                     arvalid <= !op_wr;
                     state   <= S_ISSUE_A;
                  end else begin
                     state <= S_DRAIN;
                  end
               end else if (rx_last) begin
                  state <= S_IDLE;
               end
            end
            // wdata doubles as the byte shifter while no beat is pending
            S_DATA: if (acc) begin
               if (bcnt == 2'd3) begin
                  bcnt       <= '0;
                  wdata      <= {wdata[23:0], rx_data};
                  wstrb      <= 4'hF;
                  wlast      <= last_beat;
                  wvalid     <= 1'b1;
                  pad_pend   <= rx_last && !last_beat;
                  drain_pend <= !rx_last && last_beat;
                  state      <= S_BEAT;
               end else if (rx_last) begin
                  bcnt   <= '0;
                  wdata  <= '0;
                  wstrb  <= '0;
                  wlast  <= last_beat;
                  wvalid <= 1'b1;
                  state  <= S_PAD;
               end else begin
                  bcnt  <= bcnt + 2'd1;
                  wdata <= {wdata[23:0], rx_data};
               end
            end
            S_BEAT: if (wready) begin
               beat <= nbeat;
               if (last_beat) begin
                  wvalid <= 1'b0;
                  wlast  <= 1'b0;
                  state  <= drain_pend ? S_DRAIN : S_IDLE;
               end else if (pad_pend) begin
                  wdata <= '0;
                  wstrb <= '0;
                  wlast <= nbeat == len;
                  state <= S_PAD;
               end else begin
                  wvalid <= 1'b0;
                  state  <= S_DATA;
               end
            end
            S_PAD: if (wready) begin
               beat <= nbeat;
               if (last_beat) begin
                  wvalid <= 1'b0;
                  wlast  <= 1'b0;
                  state  <= S_IDLE;
               end else begin
                  wlast <= nbeat == len;
               end
            end
            S_ISSUE_A: if ((awvalid && awready) || (arvalid && arready)) begin
               awvalid <= 1'b0;
               arvalid <= 1'b0;
               state   <= S_IDLE;
            end
            S_DRAIN: if (acc && rx_last) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_cmd_decoder.sv
// Bench for udp_cmd_decoder: frame-level model feeding expectation queues,
// one negedge monitor comparing every handshake, plus literal pins.
module tb_udp_cmd_decoder;

   typedef logic [7:0] bq_t [$];

   typedef struct packed {
      logic        wr;
      logic [1:0]  id;
      logic [1:0]  burst;
      logic [7:0]  len;
      logic [31:0] addr;
   } a_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } w_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_last;
   logic        rx_ready;
   logic [1:0]  awid, arid, awburst, arburst;
   logic [7:0]  awlen, arlen;
   logic [31:0] awaddr, araddr;
   logic        awvalid, arvalid, awready, arready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [7:0]  err_cnt;

   int errors = 0;
   int checks = 0;
   int exp_err = 0;
   a_t exp_a [$];
   w_t exp_w [$];

   bit ar_block = 1'b0;
   bit w_block = 1'b0;
   bit wr_rand = 1'b0;

   int n_real = 0, n_pad = 0, n_wlast = 0, n_a = 0;
   a_t last_aw, last_ar;
   w_t last_w;

   udp_cmd_decoder dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
      .rx_ready(rx_ready),
      .awid(awid), .awburst(awburst), .awlen(awlen), .awaddr(awaddr),
      .awvalid(awvalid), .awready(awready),
      .arid(arid), .arburst(arburst), .arlen(arlen), .araddr(araddr),
      .arvalid(arvalid), .arready(arready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bump();
      if (exp_err < 255) exp_err++;
   endtask

   // Expected AXI traffic of one whole frame, straight from the frame rules
   task automatic model_frame(input bq_t f);
      int n, beats, full;
      logic [7:0] op, b1;
      a_t a;
      w_t w;
      n = f.size();
      op = f[0];
      if (op == 8'hA0 || op == 8'hA2) begin
         if (n == 6) begin
            b1 = f[1];
            a.wr = op == 8'hA0;
            a.id = b1[1:0];
            a.burst = b1[3:2];
            a.len = {5'd0, b1[6:4]};
            a.addr = {f[2], f[3], f[4], f[5]};
            exp_a.push_back(a);
         end else bump();
      end else if (op == 8'hA1) begin
         if (n < 2) bump();
         else begin
            b1 = f[1];
            beats = int'(b1[2:0]) + 1;
            full = (n - 2) / 4;
            for (int i = 0; i < beats; i++) begin
               if (i < full) begin
                  w.data = {f[2+4*i], f[3+4*i], f[4+4*i], f[5+4*i]};
                  w.strb = 4'hF;
               end else begin
                  w.data = '0;
                  w.strb = '0;
               end
               w.last = i == beats - 1;
               exp_w.push_back(w);
            end
            if (n != 2 + 4 * beats) bump();
         end
      end else bump();
   endtask

   task automatic send_bytes(input bq_t f, input bit with_last);
      bit ok;
      @(posedge clk);
      #1;
      for (int i = 0; i < f.size(); i++) begin
         rx_data = f[i];
         rx_valid = 1'b1;
         rx_last = with_last && (i == f.size() - 1);
         ok = 1'b0;
         for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (rx_ready) begin
               ok = 1'b1;
               break;
            end
         end
         @(posedge clk);
         #1;
         chk("rx_accept", 64'(ok), 64'd1);
      end
      rx_valid = 1'b0;
      rx_last = 1'b0;
   endtask

   task automatic frame(input bq_t f);
      model_frame(f);
      send_bytes(f, 1'b1);
   endtask

   task automatic wait_done();
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (exp_a.size() == 0 && exp_w.size() == 0 &&
             !awvalid && !arvalid && !wvalid) break;
      end
      chk("pending_expect", 64'(exp_a.size() + exp_w.size()), 64'd0);
      chk("err_cnt", 64'(err_cnt), 64'(exp_err));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_err = 0;
   endtask

   // Ready driver
   initial begin
      awready = 1'b1;
      arready = 1'b1;
      wready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         awready = 1'b1;
         arready = !ar_block;
         wready = w_block ? 1'b0 :
                  (wr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   // Monitor: every handshake against the model, stability while stalled
   logic [44:0] a_hold;
   logic [36:0] w_hold;
   bit a_pend = 1'b0, w_pend = 1'b0;
   always @(negedge clk) begin
      a_t got;
      w_t gw;
      if (rst) begin
         exp_a.delete();
         exp_w.delete();
         a_pend = 1'b0;
         w_pend = 1'b0;
      end else begin
         got.wr = awvalid;
         got.id = awvalid ? awid : arid;
         got.burst = awvalid ? awburst : arburst;
         got.len = awvalid ? awlen : arlen;
         got.addr = awvalid ? awaddr : araddr;
         gw.data = wdata;
         gw.strb = wstrb;
         gw.last = wlast;
         if (awvalid || arvalid || wvalid)
            chk("rx_ready_busy", 64'(rx_ready), 64'd0);
         if (a_pend) chk("a_stable", 64'(got), 64'(a_hold));
         if (w_pend) chk("w_stable", 64'(gw), 64'(w_hold));
         if ((awvalid && awready) || (arvalid && arready)) begin
            n_a++;
            chk("a_expected", 64'(exp_a.size() != 0), 64'd1);
            if (exp_a.size() != 0) chk("a_fields", 64'(got), 64'(exp_a.pop_front()));
            if (awvalid) last_aw = got;
            else last_ar = got;
         end
         if (wvalid && wready) begin
            chk("w_expected", 64'(exp_w.size() != 0), 64'd1);
            if (exp_w.size() != 0) chk("w_beat", 64'(gw), 64'(exp_w.pop_front()));
            last_w = gw;
            if (wstrb == 4'hF) n_real++;
            else n_pad++;
            if (wlast) n_wlast++;
         end
         a_pend = (awvalid && !awready) || (arvalid && !arready);
         a_hold = got;
         w_pend = wvalid && !wready;
         w_hold = gw;
      end
   end

   initial begin
      bq_t q;
      int r0, p0, l0, a0;
      rst = 1'b1;
      rx_data = '0;
      rx_valid = 1'b0;
      rx_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rx_ready", 64'(rx_ready), 64'd0);
      chk("rst_valids", 64'({awvalid, arvalid, wvalid, wlast}), 64'd0);
      chk("rst_fields", 64'({awaddr, wdata, wstrb}), 64'd0);
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);
      rst = 1'b0;

      // Read address, arready held off for 3 cycles
      ar_block = 1'b1;
      frame('{8'hA2, 8'h04, 8'h10, 8'h00, 8'h00, 8'h00});
      chk("ar_rise", 64'(arvalid), 64'd1);
      repeat (3) begin
         @(negedge clk);
         chk("ar_hold_valid", 64'(arvalid), 64'd1);
         chk("ar_hold_addr", 64'(araddr), 64'h1000_0000);
         chk("ar_hold_rx_ready", 64'(rx_ready), 64'd0);
      end
      ar_block = 1'b0;
      wait_done();
      chk("ar_lit", 64'({last_ar.id, last_ar.burst, last_ar.len, last_ar.addr}),
          64'({2'd0, 2'd1, 8'd0, 32'h1000_0000}));

      // Write address then a 4-beat write burst
      r0 = n_real;
      l0 = n_wlast;
      frame('{8'hA0, 8'h32, 8'h10, 8'h00, 8'h00, 8'h02});
      q = '{8'hA1, 8'h03};
      for (int i = 0; i < 4; i++) begin
         q.push_back(8'h12); q.push_back(8'h34);
         q.push_back(8'h56); q.push_back(8'h78);
      end
      frame(q);
      wait_done();
      chk("aw_lit", 64'({last_aw.id, last_aw.burst, last_aw.len, last_aw.addr}),
          64'({2'd2, 2'd0, 8'd3, 32'h1000_0002}));
      chk("w4_real", 64'(n_real - r0), 64'd4);
      chk("w4_wlast", 64'(n_wlast - l0), 64'd1);
      chk("w4_data", 64'(last_w), 64'({32'h1234_5678, 4'hF, 1'b1}));

      // len=5 with rx_last after two words: padded to 6 beats
      do_reset();
      r0 = n_real;
      p0 = n_pad;
      l0 = n_wlast;
      frame('{8'hA1, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88});
      wait_done();
      chk("pad_real", 64'(n_real - r0), 64'd2);
      chk("pad_pad", 64'(n_pad - p0), 64'd4);
      chk("pad_wlast", 64'(n_wlast - l0), 64'd1);
      chk("pad_err_lit", 64'(err_cnt), 64'd1);
      chk("pad_last_beat", 64'(last_w), 64'({32'h0, 4'h0, 1'b1}));

      // Malformed frames
      a0 = n_a;
      r0 = n_real;
      frame('{8'h55, 8'h11, 8'h22});
      wait_done();
      chk("unk_err_lit", 64'(err_cnt), 64'd2);
      frame('{8'hA0, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
      wait_done();
      chk("long_addr_err_lit", 64'(err_cnt), 64'd3);
      frame('{8'hA2, 8'h00, 8'h10});
      wait_done();
      chk("short_addr_none", 64'(n_a - a0), 64'd0);
      frame('{8'hA1, 8'h00, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h01, 8'h02});
      wait_done();
      chk("extra_one_beat", 64'(n_real - r0), 64'd1);
      chk("extra_beat_lit", 64'(last_w), 64'({32'hCAFE_BABE, 4'hF, 1'b1}));
      frame('{8'hA2, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h40});
      wait_done();

      // 8-beat burst under random wready
      wr_rand = 1'b1;
      r0 = n_real;
      q = '{8'hA1, 8'h07};
      for (int i = 0; i < 32; i++) q.push_back(8'(i * 7 + 3));
      frame(q);
      wait_done();
      wr_rand = 1'b0;
      chk("rand_beats", 64'(n_real - r0), 64'd8);

      // err_cnt saturation
      for (int i = 0; i < 260; i++) frame('{8'h55});
      wait_done();
      chk("err_sat_lit", 64'(err_cnt), 64'hFF);

      // Reset while a beat is pending
      w_block = 1'b1;
      send_bytes('{8'hA1, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0);
      chk("pre_rst_wvalid", 64'(wvalid), 64'd1);
      chk("pre_rst_wdata", 64'(wdata), 64'hDEAD_BEEF);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_valids", 64'({awvalid, arvalid, wvalid, wlast}), 64'd0);
      chk("async_fields", 64'({wdata, wstrb, araddr[15:0]}), 64'd0);
      chk("async_err_cnt", 64'(err_cnt), 64'd0);
      chk("async_rx_ready", 64'(rx_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_err = 0;
      w_block = 1'b0;
      frame('{8'hBE, 8'hEF});
      frame('{8'hA2, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h40});
      wait_done();
      chk("post_rst_ar", 64'({last_ar.id, last_ar.burst, last_ar.addr}),
          64'({2'd1, 2'd3, 32'h40}));
      chk("post_rst_err_lit", 64'(err_cnt), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
